// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: a captured 16-byte state is substituted LANES bytes per clock
// through per-lane inverse S-box tables, with a valid/ready handshake on both sides.
module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out,
    output logic         busy
);

    localparam int NCHUNK = 16 / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    // FIPS-197 inverse S-box; entry b sits at bits [8b +: 8], entry 0 leftmost.
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        inv_sbox = INV_SBOX[8*int'(b) +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt;
    logic [CW-1:0]   cnt_r;
    logic [0:127]    cap_r;
    logic [0:127]    state_out_r;
    logic            out_valid_r;
    logic            last_chunk;
    logic [7:0]      lane_byte [LANES];

    assign last_chunk = (cnt_r == LAST);

    // One inverse S-box per lane, fed from the captured copy at the current chunk.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_byte[l] = inv_sbox(cap_r[(int'(cnt_r) * LANES + l) * 8 +: 8]);
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nxt = RUN;
                else          state_nxt = IDLE;
            end
            RUN: begin
                if (last_chunk) state_nxt = DONE;
                else            state_nxt = RUN;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
                else           state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt;
    end

    // Datapath: capture, per-chunk substitution and the registered out_valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= {CW{1'b0}};
            cap_r       <= 128'h0;
            state_out_r <= 128'h0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        cap_r <= state_in;
                        cnt_r <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        state_out_r[(int'(cnt_r) * LANES + l) * 8 +: 8] <= lane_byte[l];
                    end
                    if (last_chunk) begin
                        cnt_r       <= {CW{1'b0}};
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_r <= 1'b0;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign state_out = state_out_r;

endmodule
